// File: rtl/led_status_blinker_if.sv
// Status flags in, blink/strobe/LED outputs out for the front-panel status block.
interface led_status_blinker_if;
  logic       rx_ready;
  logic       rx_dec_err;
  logic       rx_ovf_err;
  logic       rx_fifo_full;
  logic       fifo_full;
  logic       clk_locked;
  logic       clk_slow;
  logic       ce_slow;
  logic       clk_fast;
  logic       ce_fast;
  logic [4:0] led;

  modport master (
    output rx_ready, rx_dec_err, rx_ovf_err, rx_fifo_full, fifo_full, clk_locked,
    input  clk_slow, ce_slow, clk_fast, ce_fast, led
  );

  modport slave (
    input  rx_ready, rx_dec_err, rx_ovf_err, rx_fifo_full, fifo_full, clk_locked,
    output clk_slow, ce_slow, clk_fast, ce_fast, led
  );
endinterface

// File: rtl/led_status_blinker.sv
// Slow/fast blink dividers with CE strobes, status-flag synchronisers and
// front-panel LED drive (receiver health on LED[3], system alive on LED[4]).
module led_status_blinker #(
  parameter int unsigned SLOW_DIVISOR = 40000000,
  parameter int unsigned FAST_DIVISOR = 13333333
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  led_status_blinker_if.slave  stat_if
);

  localparam int unsigned SLOW_W = (SLOW_DIVISOR > 2) ? $clog2(SLOW_DIVISOR) : 1;
  localparam int unsigned FAST_W = (FAST_DIVISOR > 2) ? $clog2(FAST_DIVISOR) : 1;
  localparam logic [SLOW_W-1:0] SLOW_LAST = SLOW_W'(SLOW_DIVISOR - 1);
  localparam logic [SLOW_W-1:0] SLOW_HALF = SLOW_W'(SLOW_DIVISOR / 2);
  localparam logic [FAST_W-1:0] FAST_LAST = FAST_W'(FAST_DIVISOR - 1);
  localparam logic [FAST_W-1:0] FAST_HALF = FAST_W'(FAST_DIVISOR / 2);

  localparam int unsigned NSTAT     = 6;
  localparam int unsigned S_RDY     = 0;
  localparam int unsigned S_DEC     = 1;
  localparam int unsigned S_OVF     = 2;
  localparam int unsigned S_RXFULL  = 3;
  localparam int unsigned S_FIFO    = 4;
  localparam int unsigned S_LOCK    = 5;

  logic [SLOW_W-1:0] slow_cnt_q, slow_cnt_d;
  logic [FAST_W-1:0] fast_cnt_q, fast_cnt_d;
  logic              slow_clk_q, slow_clk_d, slow_ce_q, slow_ce_d;
  logic              fast_clk_q, fast_clk_d, fast_ce_q, fast_ce_d;
  logic [NSTAT-1:0]  status_c;
  logic [NSTAT-1:0]  sync1_q, sync2_q;
  logic              led_rx_q, led_rx_d, led_alive_q, led_alive_d;

  assign status_c = {stat_if.clk_locked, stat_if.fifo_full, stat_if.rx_fifo_full,
                     stat_if.rx_ovf_err, stat_if.rx_dec_err, stat_if.rx_ready};

  // Outputs decode from the next count so they are clean flop outputs.
  always_comb begin
    slow_cnt_d  = (slow_cnt_q == SLOW_LAST) ? '0 : slow_cnt_q + SLOW_W'(1);
    fast_cnt_d  = (fast_cnt_q == FAST_LAST) ? '0 : fast_cnt_q + FAST_W'(1);
    slow_clk_d  = (slow_cnt_d >= SLOW_HALF);
    slow_ce_d   = (slow_cnt_d == SLOW_LAST);
    fast_clk_d  = (fast_cnt_d >= FAST_HALF);
    fast_ce_d   = (fast_cnt_d == FAST_LAST);
    led_rx_d    = sync2_q[S_RDY] &
                  ((sync2_q[S_DEC] ? fast_clk_q : slow_clk_q) |
                   sync2_q[S_OVF] | sync2_q[S_RXFULL]);
    led_alive_d = (slow_clk_q | sync2_q[S_FIFO]) & sync2_q[S_LOCK];
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      slow_cnt_q  <= '0;
      fast_cnt_q  <= '0;
      slow_clk_q  <= 1'b0;
      slow_ce_q   <= 1'b0;
      fast_clk_q  <= 1'b0;
      fast_ce_q   <= 1'b0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      led_rx_q    <= 1'b0;
      led_alive_q <= 1'b0;
    end else begin
      slow_cnt_q  <= slow_cnt_d;
      fast_cnt_q  <= fast_cnt_d;
      slow_clk_q  <= slow_clk_d;
      slow_ce_q   <= slow_ce_d;
      fast_clk_q  <= fast_clk_d;
      fast_ce_q   <= fast_ce_d;
      sync1_q     <= status_c;
      sync2_q     <= sync1_q;
      led_rx_q    <= led_rx_d;
      led_alive_q <= led_alive_d;
    end
  end

  assign stat_if.clk_slow = slow_clk_q;
  assign stat_if.ce_slow  = slow_ce_q;
  assign stat_if.clk_fast = fast_clk_q;
  assign stat_if.ce_fast  = fast_ce_q;
  assign stat_if.led      = {led_alive_q, led_rx_q, 3'b000};

endmodule

// File: tb/tb_led_status_blinker.sv
// Self-checking bench for led_status_blinker with SLOW_DIVISOR=8, FAST_DIVISOR=3.
module tb_led_status_blinker;
  localparam int NS = 8;
  localparam int NF = 3;
  localparam int HMAX = 4096;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  led_status_blinker_if bus ();

  led_status_blinker #(.SLOW_DIVISOR(NS), .FAST_DIVISOR(NF)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .stat_if(bus)
  );

  always #5 CLK = ~CLK;

  // bit order: {lock, fifo_full, rx_fifo_full, ovf, dec, ready}
  logic [5:0] cur_in = '0;
  logic [5:0] hist [0:HMAX-1];
  int k = 0;
  int n_cmp = 0;
  int n_err = 0;

  assign bus.rx_ready     = cur_in[0];
  assign bus.rx_dec_err   = cur_in[1];
  assign bus.rx_ovf_err   = cur_in[2];
  assign bus.rx_fifo_full = cur_in[3];
  assign bus.fifo_full    = cur_in[4];
  assign bus.clk_locked   = cur_in[5];

  // Model time base: edges since reset release, plus the inputs seen at each edge.
  always @(posedge CLK) begin
    if (RESET_N && k < HMAX - 1) begin
      k = k + 1;
      hist[k] = cur_in;
    end
  end
  always @(negedge RESET_N) k = 0;

  function automatic logic blink(input int kk, input int n);
    return (kk % n) >= (n / 2);
  endfunction

  function automatic logic strobe(input int kk, input int n);
    return (kk > 0) && ((kk % n) == n - 1);
  endfunction

  // LED after edge kk: inputs seen two edges earlier, blink state one edge earlier.
  function automatic logic [4:0] exp_led(input int kk);
    logic [5:0] s;
    logic cs, cf, l3, l4;
    if (kk < 3) return 5'b00000;
    s  = hist[kk-2];
    cs = blink(kk - 1, NS);
    cf = blink(kk - 1, NF);
    l3 = s[0] & ((s[1] ? cf : cs) | s[2] | s[3]);
    l4 = (cs | s[4]) & s[5];
    return {l4, l3, 3'b000};
  endfunction

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s k=%0d t=%0t: got %b expected %b", name, k, $time, act, expv);
    end
  endtask

  bit run_chk = 1'b0;
  always @(negedge CLK) begin
    if (run_chk) begin
      check("clk_slow", {4'b0, bus.clk_slow}, {4'b0, blink(k, NS)});
      check("ce_slow",  {4'b0, bus.ce_slow},  {4'b0, strobe(k, NS)});
      check("clk_fast", {4'b0, bus.clk_fast}, {4'b0, blink(k, NF)});
      check("ce_fast",  {4'b0, bus.ce_fast},  {4'b0, strobe(k, NF)});
      check("led",      bus.led,              exp_led(k));
    end
  end

  task automatic set_in(input logic [5:0] v);
    @(posedge CLK);
    #1 cur_in = v;
  endtask

  task automatic do_reset(input logic [5:0] v);
    @(negedge CLK);
    #2 RESET_N = 1'b0;
    cur_in = v;
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  initial begin
    #1 run_chk = 1'b1;
    // Phase 1: all inputs low, free-running dividers
    do_reset(6'b000000);
    repeat (2) @(negedge CLK);
    check("lit_ce_fast_k2", {4'b0, bus.ce_fast}, 5'd1);
    repeat (4) @(negedge CLK);
    check("lit_clk_slow_k6", {4'b0, bus.clk_slow}, 5'd1);
    @(negedge CLK);
    check("lit_ce_slow_k7", {4'b0, bus.ce_slow}, 5'd1);
    repeat (17) @(negedge CLK);

    // Phase 2: locked and ready from reset -> both LEDs track slow blink
    do_reset(6'b100001);
    repeat (4) @(negedge CLK);
    check("lit_led_k4", bus.led, 5'b00000);
    repeat (2) @(negedge CLK);
    check("lit_led_k6", bus.led, 5'b11000);
    repeat (14) @(negedge CLK);

    // Phase 3: decoder error switches LED[3] to fast blink, then back
    set_in(6'b100011);
    repeat (12) @(posedge CLK);
    set_in(6'b100001);
    repeat (12) @(posedge CLK);

    // Phase 4: overflow / rx fifo full force LED[3] high; ready low kills it
    set_in(6'b100101);
    repeat (4) @(negedge CLK);
    check("lit_led3_ovf", {4'b0, bus.led[3]}, 5'd1);
    set_in(6'b101001);
    repeat (8) @(posedge CLK);
    set_in(6'b101000);
    repeat (4) @(negedge CLK);
    check("lit_led3_nordy", {4'b0, bus.led[3]}, 5'd0);

    // Phase 5: fifo full forces LED[4] high; lock loss kills it
    set_in(6'b110000);
    repeat (4) @(negedge CLK);
    check("lit_led4_fifo", {4'b0, bus.led[4]}, 5'd1);
    set_in(6'b010000);
    repeat (4) @(negedge CLK);
    check("lit_led4_nolock", {4'b0, bus.led[4]}, 5'd0);
    check("lit_led_low_bits", {2'b0, bus.led[2:0]}, 5'd0);

    // Phase 6: asynchronous reset mid-count
    do_reset(6'b100001);
    repeat (5) @(negedge CLK);
    #2 RESET_N = 1'b0;
    #1;
    check("lit_async_clk_slow", {4'b0, bus.clk_slow}, 5'd0);
    check("lit_async_clk_fast", {4'b0, bus.clk_fast}, 5'd0);
    check("lit_async_ce", {3'b0, bus.ce_slow, bus.ce_fast}, 5'd0);
    check("lit_async_led", bus.led, 5'b00000);
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    repeat (6) @(negedge CLK);
    check("lit_ce_slow_k6_post", {4'b0, bus.ce_slow}, 5'd0);
    @(negedge CLK);
    check("lit_ce_slow_k7_post", {4'b0, bus.ce_slow}, 5'd1);
    repeat (10) @(negedge CLK);

    run_chk = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
